// File: rtl/multiport_regfile_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared defaults and types for the multi-port GPR file.
// Revision : 1.0  initial release
// ============================================================================
package regfile_pkg;

  localparam int C_DATA_W = 32;
  localparam int C_ADDR_W = 5;
  localparam int C_NUM_RD = 4;
  localparam int C_NUM_WR = 2;
  localparam int C_CNT_W  = 2;
  localparam int C_DEPTH  = 2 ** C_ADDR_W;

  typedef logic [C_ADDR_W-1:0] reg_addr_t;

endpackage
`default_nettype wire

// File: rtl/rf_pend_counter.sv
`default_nettype none
// ============================================================================
// Module   : rf_pend_counter
// Brief    : Saturating outstanding-write counter for one register.
// Revision : 1.0  initial release
// ============================================================================
module rf_pend_counter
  import regfile_pkg::*;
#(
  parameter int CNT_W = C_CNT_W,
  parameter int INC_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [INC_W-1:0] inc,
  input  logic [INC_W-1:0] dec,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf,
  output logic             unf
);

  localparam int C_SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 2;
  localparam logic [C_SUM_W-1:0] C_MAX = C_SUM_W'((2 ** CNT_W) - 1);

  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_next;
  logic [C_SUM_W-1:0] w_sum;

  // Two's-complement sum wide enough that the sign bit flags underflow.
  always_comb begin
    w_sum = C_SUM_W'(r_cnt) + C_SUM_W'(inc) - C_SUM_W'(dec);
    unf   = w_sum[C_SUM_W-1];
    ovf   = !unf && (w_sum > C_MAX);
    if (unf) begin
      w_next = '0;
    end else if (ovf) begin
      w_next = {CNT_W{1'b1}};
    end else begin
      w_next = w_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_next;
    end
  end

  assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/multiport_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : multiport_regfile_sb
// Brief    : Multi-port GPR file with write bypass and pending-write scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module multiport_regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = C_DATA_W,
  parameter int ADDR_W = C_ADDR_W,
  parameter int NUM_RD = C_NUM_RD,
  parameter int NUM_WR = C_NUM_WR,
  parameter int CNT_W  = C_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        iss_en,
  input  logic [NUM_WR*ADDR_W-1:0] iss_addr,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic                     sb_err
);

  localparam int C_NREG  = 2 ** ADDR_W;
  localparam int C_INC_W = $clog2(NUM_WR + 1);
  localparam int C_CMP_W = (CNT_W > C_INC_W) ? CNT_W : C_INC_W;

  logic [DATA_W-1:0]  r_mem [C_NREG];
  logic               r_sb_err;
  logic [C_INC_W-1:0] w_inc [C_NREG];
  logic [C_INC_W-1:0] w_dec [C_NREG];
  logic [CNT_W-1:0]   w_cnt [C_NREG];
  logic [C_NREG-1:0]  w_ovf;
  logic [C_NREG-1:0]  w_unf;

  always_comb begin
    for (int r = 0; r < C_NREG; r++) begin
      w_inc[r] = '0;
      w_dec[r] = '0;
    end
    for (int j = 0; j < NUM_WR; j++) begin
      if (iss_en[j] && (iss_addr[j*ADDR_W +: ADDR_W] != '0)) begin
        w_inc[iss_addr[j*ADDR_W +: ADDR_W]] = w_inc[iss_addr[j*ADDR_W +: ADDR_W]] + C_INC_W'(1);
      end
      if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != '0)) begin
        w_dec[wr_addr[j*ADDR_W +: ADDR_W]] = w_dec[wr_addr[j*ADDR_W +: ADDR_W]] + C_INC_W'(1);
      end
    end
  end

  // Ascending lane order: the last non-blocking update, i.e. the highest lane, wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < C_NREG; r++) begin
        r_mem[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != '0)) begin
          r_mem[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  for (genvar r = 0; r < C_NREG; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign w_cnt[r] = '0;
      assign w_ovf[r] = 1'b0;
      assign w_unf[r] = 1'b0;
    end else begin : g_ctr
      rf_pend_counter #(
        .CNT_W (CNT_W),
        .INC_W (C_INC_W)
      ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_inc[r]),
        .dec   (w_dec[r]),
        .cnt   (w_cnt[r]),
        .ovf   (w_ovf[r]),
        .unf   (w_unf[r])
      );
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sb_err <= 1'b0;
    end else if ((|w_ovf) || (|w_unf)) begin
      r_sb_err <= 1'b1;
    end
  end

  assign sb_err = r_sb_err;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rv;

    assign w_ra = rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      w_rv = r_mem[w_ra];
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == w_ra)) begin
          w_rv = wr_data[j*DATA_W +: DATA_W];
        end
      end
    end

    // Outputs are forced quiet while reset is held, even with writeback traffic.
    assign rd_data[i*DATA_W +: DATA_W] = (!reset || (w_ra == '0)) ? '0 : w_rv;
    assign rd_busy[i] = reset && (w_ra != '0) &&
                        (C_CMP_W'(w_cnt[w_ra]) != C_CMP_W'(w_dec[w_ra]));
  end

endmodule
`default_nettype wire

// File: tb/tb_multiport_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiport_regfile_sb
// Brief    : Scoreboard bench for multiport_regfile_sb with directed vectors.
// Revision : 1.0  initial release
// ============================================================================
module tb_multiport_regfile_sb;
  import regfile_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int NW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic [NW-1:0]    iss_en;
  logic [NW*AW-1:0] iss_addr;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic             sb_err;

  multiport_regfile_sb dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .sb_err   (sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          port;
    logic [31:0] data;
    logic        busy;
    bit          chk_err;
    logic        err;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t m_x;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc++;

  // Monitor: compares every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m_x = q.pop_front();
      if (m_x.cyc < cyc) begin
        n_chk++;
        $display("FAIL %s stale: queued cycle %0d, now %0d", m_x.name, m_x.cyc, cyc);
      end else begin
        n_chk++;
        if (rd_data[m_x.port*DW +: DW] === m_x.data) n_pass++;
        else $display("FAIL %s rd_data[%0d]: got %h expected %h", m_x.name, m_x.port,
                      rd_data[m_x.port*DW +: DW], m_x.data);
        n_chk++;
        if (rd_busy[m_x.port] === m_x.busy) n_pass++;
        else $display("FAIL %s rd_busy[%0d]: got %b expected %b", m_x.name, m_x.port,
                      rd_busy[m_x.port], m_x.busy);
        if (m_x.chk_err) begin
          n_chk++;
          if (sb_err === m_x.err) n_pass++;
          else $display("FAIL %s sb_err: got %b expected %b", m_x.name, sb_err, m_x.err);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    iss_en = '0;
    wr_en  = '0;
  endtask

  task automatic rd(input int p, input reg_addr_t a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic wr(input int l, input reg_addr_t a, input logic [31:0] d);
    wr_en[l]            = 1'b1;
    wr_addr[l*AW +: AW] = a;
    wr_data[l*DW +: DW] = d;
  endtask

  task automatic iss(input int l, input reg_addr_t a);
    iss_en[l]            = 1'b1;
    iss_addr[l*AW +: AW] = a;
  endtask

  task automatic expect_rd(input int p, input logic [31:0] d, input logic b,
                           input bit ce, input logic e, input string nm);
    exp_t x;
    x.cyc = cyc; x.port = p; x.data = d; x.busy = b;
    x.chk_err = ce; x.err = e; x.name = nm;
    q.push_back(x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset    = 1'b0;
    rd_addr  = '0;
    iss_en   = '0;
    iss_addr = '0;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;

    // Reset state on four ports
    step();
    rd(0, 5'd0); rd(1, 5'd1); rd(2, 5'd17); rd(3, 5'd31);
    expect_rd(0, 32'h0, 1'b0, 1, 1'b0, "rst_p0");
    expect_rd(1, 32'h0, 1'b0, 1, 1'b0, "rst_p1");
    expect_rd(2, 32'h0, 1'b0, 1, 1'b0, "rst_p2");
    expect_rd(3, 32'h0, 1'b0, 1, 1'b0, "rst_p3");

    // Balance the addr5 scoreboard so the dual write below is legal
    step();
    reset = 1'b1;
    iss(0, 5'd5); iss(1, 5'd5);
    rd(0, 5'd5);
    expect_rd(0, 32'h0, 1'b0, 1, 1'b0, "iss5_same_cycle");

    step();
    wr(0, 5'd5, 32'hAAAA0000); wr(1, 5'd5, 32'h5555FFFF);
    rd(1, 5'd5);
    expect_rd(0, 32'h5555FFFF, 1'b0, 0, 1'b0, "bypass_prio_p0");
    expect_rd(1, 32'h5555FFFF, 1'b0, 0, 1'b0, "bypass_prio_p1");

    step();
    expect_rd(0, 32'h5555FFFF, 1'b0, 1, 1'b0, "stored_prio");

    step();
    wr(0, 5'd0, 32'hFFFFFFFF);
    rd(0, 5'd0);
    expect_rd(0, 32'h0, 1'b0, 0, 1'b0, "wr0_same");

    step();
    expect_rd(0, 32'h0, 1'b0, 1, 1'b0, "wr0_next");

    // Normal issue -> writeback flow on addr9
    step();
    iss(0, 5'd9);
    rd(0, 5'd9);
    expect_rd(0, 32'h0, 1'b0, 0, 1'b0, "iss9_n");
    step();
    expect_rd(0, 32'h0, 1'b1, 0, 1'b0, "iss9_n1");
    step();
    expect_rd(0, 32'h0, 1'b1, 0, 1'b0, "iss9_n2");
    step();
    wr(1, 5'd9, 32'h12);
    expect_rd(0, 32'h12, 1'b0, 0, 1'b0, "wb9_n3");
    step();
    expect_rd(0, 32'h12, 1'b0, 1, 1'b0, "wb9_after");

    // Dual issue, single writeback
    step();
    iss(0, 5'd9); iss(1, 5'd9);
    expect_rd(0, 32'h12, 1'b0, 0, 1'b0, "dual_iss9");
    step();
    wr(0, 5'd9, 32'h34);
    expect_rd(0, 32'h34, 1'b1, 0, 1'b0, "single_wb9_cnt2");
    step();
    expect_rd(0, 32'h34, 1'b1, 0, 1'b0, "cnt1_busy");

    // Issue and writeback together net out
    step();
    iss(0, 5'd9); wr(1, 5'd9, 32'h56);
    expect_rd(0, 32'h56, 1'b0, 0, 1'b0, "net_same_cycle");
    step();
    expect_rd(0, 32'h56, 1'b1, 1, 1'b0, "net_cnt_stays1");
    step();
    wr(0, 5'd9, 32'h78);
    expect_rd(0, 32'h78, 1'b0, 0, 1'b0, "final_wb9");
    step();
    expect_rd(0, 32'h78, 1'b0, 1, 1'b0, "cnt9_zero");

    // Overflow: four issues to addr4
    step();
    iss(0, 5'd4); iss(1, 5'd4);
    rd(1, 5'd4);
    expect_rd(1, 32'h0, 1'b0, 1, 1'b0, "ovf_iss_a");
    step();
    iss(0, 5'd4); iss(1, 5'd4);
    expect_rd(1, 32'h0, 1'b1, 1, 1'b0, "ovf_iss_b");
    step();
    expect_rd(1, 32'h0, 1'b1, 1, 1'b1, "ovf_err");

    // Async reset mid-stream with writeback traffic on the bus
    step();
    wr(0, 5'd4, 32'hDEADBEEF); iss(0, 5'd7);
    rd(0, 5'd4);
    #2 reset = 1'b0;
    expect_rd(0, 32'h0, 1'b0, 1, 1'b0, "async_rst_p0");
    expect_rd(1, 32'h0, 1'b0, 1, 1'b0, "async_rst_p1");
    step();
    reset = 1'b1;
    expect_rd(1, 32'h0, 1'b0, 1, 1'b0, "post_rst_cnt_cleared");

    // Underflow: writeback addr3 with zero count
    step();
    wr(0, 5'd3, 32'h99);
    rd(0, 5'd3);
    expect_rd(0, 32'h99, 1'b1, 1, 1'b0, "unf_cycle");
    step();
    expect_rd(0, 32'h99, 1'b0, 1, 1'b1, "unf_err");

    step();
    step();
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations never compared, required 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
